// File: rtl/key_pkg.sv
// Shared types and default timing constants for the key event classifier.
package key_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } key_state_t;

  // 125 MHz clock: 1 s hold, 300 ms double-click window, 200 ms repeat
  localparam int unsigned KEY_LONG_CNT   = 125_000_000;
  localparam int unsigned KEY_DCLICK_CNT = 37_500_000;
  localparam int unsigned KEY_REPEAT_CNT = 25_000_000;

  localparam logic [31:0] KEY_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/key_event_if.sv
// Key level in, classified key events out.
interface key_event_if;
  logic kin;
  logic pressed;
  logic short_press;
  logic long_press;
  logic double_click;
  logic repeat_pulse;

  modport master (output kin,
                  input  pressed, short_press, long_press, double_click, repeat_pulse);
  modport slave  (input  kin,
                  output pressed, short_press, long_press, double_click, repeat_pulse);
endinterface

// File: rtl/key_edge.sv
// One-cycle delay of the key level plus press (fall) / release (rise) decode.
module key_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic kin_i,
  output logic fall_o,
  output logic rise_o
);

  logic kin_d_q;

  // Resetting to 0 means a key held through reset never produces a fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) kin_d_q <= 1'b0;
    else        kin_d_q <= kin_i;
  end

  assign fall_o =  kin_d_q & ~kin_i;
  assign rise_o = ~kin_d_q &  kin_i;

endmodule

// File: rtl/key_event.sv
// Classifies a debounced key into short press, long press, double click and
// (with KEY_EVENT_REPEAT_EN defined) auto-repeat pulses.
module key_event
  import key_pkg::*;
#(
  parameter int unsigned LONG_CNT   = KEY_LONG_CNT,
  parameter int unsigned DCLICK_CNT = KEY_DCLICK_CNT,
  parameter int unsigned REPEAT_CNT = KEY_REPEAT_CNT
) (
  input  logic        clk,
  input  logic        rst_n,
  key_event_if.slave  kif
);

  localparam logic [31:0] LONG_LAST   = 32'(LONG_CNT - 1);
  localparam logic [31:0] DCLICK_LAST = 32'(DCLICK_CNT - 1);

  // Windows shorter than two cycles cannot be told apart from the entry edge.
  if (LONG_CNT < 2 || DCLICK_CNT < 2 || REPEAT_CNT < 1) begin : g_cnt_param_small
  end

  logic fall, rise;

  key_edge u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .kin_i  (kif.kin),
    .fall_o (fall),
    .rise_o (rise)
  );

  key_state_t  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        pressed_q;
  logic        sp_q, sp_d, lp_q, lp_d, dc_q, dc_d;
`ifdef KEY_EVENT_REPEAT_EN
  localparam logic [31:0] REPEAT_LAST = 32'(REPEAT_CNT - 1);
  logic        rp_q, rp_d;
`endif

  always_comb begin
    state_d = state_q;
    sp_d    = 1'b0;
    lp_d    = 1'b0;
    dc_d    = 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
    rp_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE:   if (fall) state_d = PRESS1;
      PRESS1: begin
        if (!kif.kin && cnt_q == LONG_LAST) begin
          state_d = LONG;
          lp_d    = 1'b1;
        end else if (rise) begin
          state_d = WAIT2;
        end
      end
      // The window expiring wins over a coincident press.
      WAIT2: begin
        if (cnt_q >= DCLICK_LAST) begin
          state_d = IDLE;
          sp_d    = 1'b1;
        end else if (fall) begin
          state_d = PRESS2;
        end
      end
      PRESS2: begin
        if (rise) begin
          state_d = IDLE;
          dc_d    = 1'b1;
        end
      end
      LONG: begin
        if (rise) state_d = IDLE;
`ifdef KEY_EVENT_REPEAT_EN
        else if (!kif.kin && cnt_q == REPEAT_LAST) rp_d = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase

    cnt_d = cnt_q;
    if (state_d != state_q)
      cnt_d = '0;
    else if ((state_q == PRESS1 || state_q == WAIT2 || state_q == LONG) &&
             cnt_q != KEY_CNT_MAX)
      cnt_d = cnt_q + 32'd1;
`ifdef KEY_EVENT_REPEAT_EN
    if (rp_d) cnt_d = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
      sp_q      <= 1'b0;
      lp_q      <= 1'b0;
      dc_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pressed_q <= ~kif.kin;
      sp_q      <= sp_d;
      lp_q      <= lp_d;
      dc_q      <= dc_d;
    end
  end

`ifdef KEY_EVENT_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rp_q <= 1'b0;
    else        rp_q <= rp_d;
  end
  assign kif.repeat_pulse = rp_q;
`else
  assign kif.repeat_pulse = 1'b0;
`endif

  assign kif.pressed      = pressed_q;
  assign kif.short_press  = sp_q;
  assign kif.long_press   = lp_q;
  assign kif.double_click = dc_q;

endmodule

// File: tb/tb_key_event.sv
// Randomized + directed bench for key_event against a timestamp-based model.
module tb_key_event;

  localparam int LC = 100;
  localparam int DC = 30;
  localparam int RC = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  key_event_if kif ();

  key_event #(.LONG_CNT(LC), .DCLICK_CNT(DC), .REPEAT_CNT(RC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif)
  );

  int ncmp = 0;
  int nerr = 0;

  // Behavioural model: key activity phases tracked by edge timestamps.
  int pc = 0;
  int phase = 0;  // 0 none, 1 first press held, 2 released, 3 held long, 4 second press
  int t0 = 0;
  bit mk_d = 1'b0;
  bit e_pr = 0, e_sp = 0, e_lp = 0, e_dc = 0, e_rp = 0;

  always @(posedge clk) begin
    bit k, fl, rs;
    pc++;
    k = kif.kin;
    e_sp = 0; e_lp = 0; e_dc = 0; e_rp = 0;
    if (!rst_n) begin
      phase = 0; mk_d = 0; e_pr = 0;
    end else begin
      fl = mk_d & ~k;
      rs = ~mk_d & k;
      e_pr = ~k;
      case (phase)
        0: if (fl) begin phase = 1; t0 = pc; end
        1: if (!k && pc - t0 == LC) begin e_lp = 1; phase = 3; t0 = pc; end
           else if (rs) begin phase = 2; t0 = pc; end
        2: if (pc - t0 >= DC) begin e_sp = 1; phase = 0; end
           else if (fl) phase = 4;
        3: begin
          if (rs) phase = 0;
`ifdef KEY_EVENT_REPEAT_EN
          else if (!k && pc - t0 == RC) begin e_rp = 1; t0 = pc; end
`endif
        end
        default: if (rs) begin e_dc = 1; phase = 0; end
      endcase
      mk_d = k;
    end
  end

  // Observed pulse bookkeeping for the literal pins.
  int sp_n, lp_n, dc_n, rp_n, sp_t, lp_t, dc_t, rp_t;

  task automatic clr();
    sp_n = 0; lp_n = 0; dc_n = 0; rp_n = 0;
    sp_t = 0; lp_t = 0; dc_t = 0; rp_t = 0;
  endtask

  task automatic cmp1(string nm, logic act, logic exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at edge %0d: got %b want %b", nm, pc, act, exp);
    end
  endtask

  task automatic lit(string nm, int act, int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(negedge clk);
      cmp1("pressed",      kif.pressed,      e_pr);
      cmp1("short_press",  kif.short_press,  e_sp);
      cmp1("long_press",   kif.long_press,   e_lp);
      cmp1("double_click", kif.double_click, e_dc);
      cmp1("repeat_pulse", kif.repeat_pulse, e_rp);
      if (kif.short_press)  begin sp_n++; sp_t = pc; end
      if (kif.long_press)   begin lp_n++; lp_t = pc; end
      if (kif.double_click) begin dc_n++; dc_t = pc; end
      if (kif.repeat_pulse) begin if (rp_n == 0) rp_t = pc; rp_n++; end
    end
  endtask

  initial begin
    int tp, tr;
    kif.kin = 1'b1;
    clr();
    cyc(3);
    lit("reset_pressed", int'(kif.pressed), 0);
    lit("reset_pulses", int'(kif.short_press | kif.long_press | kif.double_click | kif.repeat_pulse), 0);
    rst_n = 1'b1;
    cyc(5);

    // Single short click
    clr();
    kif.kin = 0; cyc(10);
    kif.kin = 1; tr = pc + 1; cyc(45);
    lit("short_count", sp_n, 1);
    lit("short_latency", sp_t - tr, DC);
    lit("short_others", lp_n + dc_n + rp_n, 0);

    // Double click
    clr();
    kif.kin = 0; cyc(10);
    kif.kin = 1; cyc(10);
    kif.kin = 0; cyc(5);
    kif.kin = 1; tr = pc + 1; cyc(40);
    lit("dclick_count", dc_n, 1);
    lit("dclick_latency", dc_t - tr, 0);
    lit("dclick_no_short", sp_n + lp_n + rp_n, 0);

    // Long hold
    clr();
    kif.kin = 0; tp = pc + 1; cyc(165);
    kif.kin = 1; cyc(40);
    lit("long_count", lp_n, 1);
    lit("long_latency", lp_t - tp, LC);
`ifdef KEY_EVENT_REPEAT_EN
    lit("repeat_count", rp_n, 3);
    lit("repeat_first", rp_t - lp_t, RC);
`else
    lit("repeat_count", rp_n, 0);
`endif
    lit("long_others", sp_n + dc_n, 0);

    // Key held through reset release: only the next press counts
    clr();
    kif.kin = 0; cyc(3);
    rst_n = 0; cyc(3);
    rst_n = 1; cyc(20);
    lit("held_reset_quiet", sp_n + lp_n + dc_n + rp_n, 0);
    kif.kin = 1; cyc(5);
    kif.kin = 0; cyc(10);
    kif.kin = 1; cyc(45);
    lit("held_reset_short", sp_n, 1);
    lit("held_reset_others", lp_n + dc_n + rp_n, 0);

    // Reset during the double-click window discards the click
    clr();
    kif.kin = 0; cyc(5);
    kif.kin = 1; cyc(10);
    rst_n = 0; cyc(3);
    rst_n = 1; cyc(40);
    lit("wait2_reset_no_short", sp_n + lp_n + dc_n + rp_n, 0);
    kif.kin = 0; cyc(5);
    kif.kin = 1; cyc(40);
    lit("after_reset_short", sp_n, 1);

    // Random key activity
    for (int i = 0; i < 60; i++) begin
      int sel, lo, hi;
      sel = $urandom_range(0, 5);
      if (sel < 3)       lo = $urandom_range(1, 20);
      else if (sel == 3) lo = $urandom_range(90, 130);
      else               lo = $urandom_range(130, 200);
      hi = (sel == 5) ? $urandom_range(25, 40) : $urandom_range(1, 50);
      kif.kin = 0; cyc(lo);
      kif.kin = 1; cyc(hi);
      if ($urandom_range(0, 14) == 0) begin
        rst_n = 0; cyc($urandom_range(1, 3));
        rst_n = 1; cyc(2);
      end
    end
    cyc(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/key_event.md
KEY_EVENT -- requirements
Module: key_event

Interface
REQ-001 Parameter LONG_CNT, default 125_000_000, is the hold time in clk cycles that qualifies a long press (1 s at 125 MHz).
REQ-002 Parameter DCLICK_CNT, default 37_500_000, is the release window in clk cycles for a second press to form a double click (300 ms).
REQ-003 Parameter REPEAT_CNT, default 25_000_000, is the auto-repeat period in clk cycles while a long press is held (200 ms).
REQ-004 clk  input  1  system clock, 125 MHz; the single clock.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 kin  input  1  debounced key level from the debouncer, same clock domain: 0 = pressed, 1 = released.
REQ-007 pressed  output  1  registered ~kin.
REQ-008 short_press  output  1  one-cycle pulse for a single short click.
REQ-009 long_press  output  1  one-cycle pulse when the hold time reaches LONG_CNT.
REQ-010 double_click  output  1  one-cycle pulse for two clicks inside the window.
REQ-011 repeat_pulse  output  1  one-cycle auto-repeat pulse during a long hold.

Function
REQ-012 kin SHALL be sampled at each posedge, and fall = kin_d & ~kin, rise = ~kin_d & kin, where kin_d is kin delayed one cycle.
REQ-013 The FSM states SHALL be IDLE, PRESS1, WAIT2, PRESS2 and LONG, and a single 32-bit counter cnt is cleared on every state change.
REQ-014 IDLE: on fall, go to PRESS1; otherwise stay.
REQ-015 PRESS1: on rise with cnt < LONG_CNT-1, go to WAIT2; when cnt = LONG_CNT-1 and kin = 0, go to LONG and pulse long_press.
REQ-016 WAIT2: on fall with cnt < DCLICK_CNT-1, go to PRESS2; when cnt = DCLICK_CNT-1 and no fall, go to IDLE and pulse short_press.
REQ-017 PRESS2: on rise, go to IDLE and pulse double_click; the duration of the second press is not timed.
REQ-018 LONG: on rise, go to IDLE with no pulse.
REQ-019 Every pulse SHALL be registered and high for exactly the one cycle after the edge at which its transition is taken; at most one event pulse is high in any cycle.
REQ-020 cnt SHALL saturate and never wrap; it increments only in PRESS1, WAIT2 and LONG.
REQ-021 Latency: short_press fires DCLICK_CNT cycles after the release, and long_press fires LONG_CNT cycles after the press, each +1 cycle for registration.

Reset
REQ-022 While rst_n = 0, the FSM SHALL be IDLE, cnt = 0, and all outputs are 0.
REQ-023 kin_d SHALL reset to 0, so a key held through reset is ignored until it is released and pressed again.
REQ-024 Reset asserted mid-sequence SHALL discard the sequence with no pulse, at reset or after it.

Configuration
REQ-025 With KEY_EVENT_REPEAT_EN defined, in LONG, when cnt = REPEAT_CNT-1 with kin = 0, repeat_pulse SHALL fire and cnt clears; the first repeat comes REPEAT_CNT cycles after long_press.
REQ-026 With KEY_EVENT_REPEAT_EN undefined, repeat_pulse SHALL be tied to 0, the repeat compare logic is absent, and REPEAT_CNT is unused.

Structure
REQ-027 Package key_pkg SHALL hold the state enum key_state_t and the default constants KEY_LONG_CNT, KEY_DCLICK_CNT and KEY_REPEAT_CNT.
REQ-028 Sub-module key_edge (kin_d register plus fall/rise decode, reset value 0) SHALL be instantiated once; the FSM, counter and pulses live in key_event.

Verification (LONG_CNT=100, DCLICK_CNT=30, REPEAT_CNT=20)
REQ-029 kin low 10 cycles then high -> single short_press 30+1 cycles after the rise; no other pulse.
REQ-030 kin low 10, high 10, low 5, high -> double_click 1 cycle after the second rise; no short_press.
REQ-031 kin low 165 cycles with REPEAT_EN -> long_press at press+101, repeat_pulse at +121, +141, +161; no pulse on release.
REQ-032 Same stimulus without REPEAT_EN -> one long_press, repeat_pulse constantly 0.
REQ-033 kin held low across the rst_n release, then high 5 and low 10 -> only the second press is recognised (short_press); no pulse before it.
REQ-034 rst_n pulsed low during WAIT2 -> no short_press; pressed and the pulses are 0 during reset; the next click behaves normally.
